// File: rtl/lii_gearbox_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : lii_gearbox_wrapper
// Purpose  : LII phy <-> HLS stream gearbox (PW-bit beats to IW/OW words)
// Revision : 1.0 - initial release
// ============================================================================
module lii_gearbox_wrapper #(
  parameter int         PW     = 64,
  parameter int         IW     = 16,
  parameter int         OW     = 32,
  parameter logic [7:0] MY_ID  = 8'd0,
  parameter logic [7:0] DST_ID = 8'd1
) (
  input  logic          aclk,
  input  logic          arstn,
  input  logic [PW-1:0] lii_in_p0_tdata,
  input  logic          lii_in_p0_tvalid,
  output logic          lii_in_p0_tready,
  input  logic [7:0]    lii_in_p0_src,
  input  logic [7:0]    lii_in_p0_dst,
  output logic [PW-1:0] lii_out_p0_tdata,
  output logic          lii_out_p0_tvalid,
  input  logic          lii_out_p0_tready,
  output logic [7:0]    lii_out_p0_src,
  output logic [7:0]    lii_out_p0_dst,
  output logic [IW-1:0] in_stream_tdata,
  output logic          in_stream_tvalid,
  input  logic          in_stream_tready,
  input  logic [OW-1:0] out_stream_tdata,
  input  logic          out_stream_tvalid,
  output logic          out_stream_tready,
  input  logic          out_stream_tlast,
  output logic          ce,
  output logic [15:0]   drop_count
);

  localparam int c_K_IN  = PW / IW;
  localparam int c_K_OUT = PW / OW;
  localparam int c_ICW   = (c_K_IN  > 1) ? $clog2(c_K_IN)  : 1;
  localparam int c_OCW   = (c_K_OUT > 1) ? $clog2(c_K_OUT) : 1;
  localparam logic [c_ICW-1:0] c_ICNT_LAST = c_ICW'(c_K_IN - 1);
  localparam logic [c_OCW-1:0] c_OCNT_LAST = c_OCW'(c_K_OUT - 1);

  // ---------------------------------------------------------------- input
  logic [PW-1:0]    r_ibuf;
  logic             r_ibuf_valid;
  logic [c_ICW-1:0] r_icnt;
  logic [15:0]      r_drop_count;

  logic w_in_last;
  logic w_in_xfer;
  logic w_in_match;
  logic w_word_xfer;
  logic w_unused_src;

  assign w_in_last        = (r_icnt == c_ICNT_LAST);
  assign lii_in_p0_tready = !r_ibuf_valid | (in_stream_tready & w_in_last);
  assign w_in_xfer        = lii_in_p0_tvalid & lii_in_p0_tready;
  assign w_in_match       = (lii_in_p0_dst == MY_ID);
  assign w_word_xfer      = r_ibuf_valid & in_stream_tready;
  assign w_unused_src     = &{1'b0, lii_in_p0_src};

  assign in_stream_tvalid = r_ibuf_valid;
  assign in_stream_tdata  = r_ibuf[int'(r_icnt)*IW +: IW];
  assign drop_count       = r_drop_count;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_ibuf       <= '0;
      r_ibuf_valid <= 1'b0;
      r_icnt       <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_word_xfer) begin
        if (w_in_last) begin
          r_icnt       <= '0;
          r_ibuf_valid <= 1'b0;
        end else begin
          r_icnt <= r_icnt + 1'b1;
        end
      end
      // A matching load wins over the free on the same edge
      if (w_in_xfer && w_in_match) begin
        r_ibuf       <= lii_in_p0_tdata;
        r_ibuf_valid <= 1'b1;
        r_icnt       <= '0;
      end
      if (w_in_xfer && !w_in_match && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------- output
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_obuf;
  logic             r_obuf_valid;
  logic [c_OCW-1:0] r_ocnt;

  logic          w_stall;
  logic          w_out_xfer;
  logic          w_flush;
  logic [PW-1:0] w_acc_next;
  logic [PW-1:0] w_beat;

  assign w_stall           = r_obuf_valid & !lii_out_p0_tready;
  assign out_stream_tready = !w_stall;
  assign ce                = !w_stall;
  assign w_out_xfer        = out_stream_tvalid & !w_stall;
  assign w_flush           = (r_ocnt == c_OCNT_LAST) | out_stream_tlast;

  assign lii_out_p0_tdata  = r_obuf;
  assign lii_out_p0_tvalid = r_obuf_valid;
  assign lii_out_p0_src    = MY_ID;
  assign lii_out_p0_dst    = DST_ID;

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_ocnt)*OW +: OW] = out_stream_tdata;
    w_beat = w_acc_next;
    // Lanes above the current word are zeroed on an early flush
    for (int l = 0; l < c_K_OUT; l++) begin
      if (l > int'(r_ocnt)) begin
        w_beat[l*OW +: OW] = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_acc        <= '0;
      r_obuf       <= '0;
      r_obuf_valid <= 1'b0;
      r_ocnt       <= '0;
    end else begin
      if (r_obuf_valid && lii_out_p0_tready) begin
        r_obuf_valid <= 1'b0;
      end
      if (w_out_xfer) begin
        if (w_flush) begin
          r_obuf       <= w_beat;
          r_obuf_valid <= 1'b1;
          r_ocnt       <= '0;
          r_acc        <= '0;
        end else begin
          r_acc  <= w_acc_next;
          r_ocnt <= r_ocnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lii_gearbox_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_lii_gearbox_wrapper
// Purpose  : Directed self-checking bench for lii_gearbox_wrapper
// Revision : 1.0 - initial release
// ============================================================================
module tb_lii_gearbox_wrapper;

  logic        aclk;
  logic        arstn;
  logic [63:0] lii_in_p0_tdata;
  logic        lii_in_p0_tvalid;
  logic        lii_in_p0_tready;
  logic [7:0]  lii_in_p0_src;
  logic [7:0]  lii_in_p0_dst;
  logic [63:0] lii_out_p0_tdata;
  logic        lii_out_p0_tvalid;
  logic        lii_out_p0_tready;
  logic [7:0]  lii_out_p0_src;
  logic [7:0]  lii_out_p0_dst;
  logic [15:0] in_stream_tdata;
  logic        in_stream_tvalid;
  logic        in_stream_tready;
  logic [31:0] out_stream_tdata;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        out_stream_tlast;
  logic        ce;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;

  lii_gearbox_wrapper #(
    .PW(64), .IW(16), .OW(32), .MY_ID(8'd0), .DST_ID(8'd1)
  ) dut (
    .aclk              (aclk),
    .arstn             (arstn),
    .lii_in_p0_tdata   (lii_in_p0_tdata),
    .lii_in_p0_tvalid  (lii_in_p0_tvalid),
    .lii_in_p0_tready  (lii_in_p0_tready),
    .lii_in_p0_src     (lii_in_p0_src),
    .lii_in_p0_dst     (lii_in_p0_dst),
    .lii_out_p0_tdata  (lii_out_p0_tdata),
    .lii_out_p0_tvalid (lii_out_p0_tvalid),
    .lii_out_p0_tready (lii_out_p0_tready),
    .lii_out_p0_src    (lii_out_p0_src),
    .lii_out_p0_dst    (lii_out_p0_dst),
    .in_stream_tdata   (in_stream_tdata),
    .in_stream_tvalid  (in_stream_tvalid),
    .in_stream_tready  (in_stream_tready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .out_stream_tlast  (out_stream_tlast),
    .ce                (ce),
    .drop_count        (drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    out_stream_tvalid = 1'b1;
    out_stream_tdata  = w;
    out_stream_tlast  = last;
    tick();
    out_stream_tvalid = 1'b0;
    out_stream_tlast  = 1'b0;
  endtask

  initial begin
    arstn             = 1'b0;
    lii_in_p0_tdata   = '0;
    lii_in_p0_tvalid  = 1'b0;
    lii_in_p0_src     = 8'h00;
    lii_in_p0_dst     = 8'h00;
    lii_out_p0_tready = 1'b1;
    in_stream_tready  = 1'b1;
    out_stream_tdata  = '0;
    out_stream_tvalid = 1'b0;
    out_stream_tlast  = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_out_tvalid", 64'(lii_out_p0_tvalid), 64'd0);
    check("rst_in_tvalid",  64'(in_stream_tvalid),  64'd0);
    check("rst_out_tdata",  lii_out_p0_tdata,       64'd0);
    check("rst_ce",         64'(ce),                64'd1);
    check("rst_drop",       64'(drop_count),        64'd0);
    check("rst_in_tready",  64'(lii_in_p0_tready),  64'd1);
    check("out_src",        64'(lii_out_p0_src),    64'h00);
    check("out_dst",        64'(lii_out_p0_dst),    64'h01);
    arstn = 1'b1;
    tick();

    // unpack with back-to-back beats
    lii_in_p0_tvalid = 1'b1;
    lii_in_p0_dst    = 8'h00;
    lii_in_p0_src    = 8'h3C;
    lii_in_p0_tdata  = 64'h4444_3333_2222_1111;
    tick();
    lii_in_p0_tdata  = 64'h8888_7777_6666_5555;
    check("unp_w0_valid", 64'(in_stream_tvalid), 64'd1);
    check("unp_w0",       64'(in_stream_tdata),  64'h1111);
    check("unp_w0_rdy",   64'(lii_in_p0_tready), 64'd0);
    tick();
    check("unp_w1",       64'(in_stream_tdata),  64'h2222);
    check("unp_w1_rdy",   64'(lii_in_p0_tready), 64'd0);
    tick();
    check("unp_w2",       64'(in_stream_tdata),  64'h3333);
    tick();
    check("unp_w3",       64'(in_stream_tdata),  64'h4444);
    check("unp_w3_rdy",   64'(lii_in_p0_tready), 64'd1);
    tick();
    lii_in_p0_tvalid = 1'b0;
    check("unp_b2_valid", 64'(in_stream_tvalid), 64'd1);
    check("unp_b2_w0",    64'(in_stream_tdata),  64'h5555);
    tick();
    tick();
    tick();
    check("unp_b2_w3",    64'(in_stream_tdata),  64'h8888);
    tick();
    check("unp_idle",     64'(in_stream_tvalid), 64'd0);

    // destination filter
    lii_in_p0_tvalid = 1'b1;
    lii_in_p0_dst    = 8'h05;
    lii_in_p0_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flt_no_valid", 64'(in_stream_tvalid), 64'd0);
    end
    check("flt_drop3", 64'(drop_count), 64'd3);
    lii_in_p0_dst   = 8'h00;
    lii_in_p0_tdata = 64'hDDDD_CCCC_BBBB_AAAA;
    tick();
    lii_in_p0_tvalid = 1'b0;
    check("flt_pass_valid", 64'(in_stream_tvalid), 64'd1);
    check("flt_pass_w0",    64'(in_stream_tdata),  64'hAAAA);
    check("flt_drop_hold",  64'(drop_count),       64'd3);
    tick();
    check("flt_pass_w1",    64'(in_stream_tdata),  64'hBBBB);
    tick();
    tick();
    tick();
    check("flt_idle",       64'(in_stream_tvalid), 64'd0);

    // pack two words into one beat
    check("pk_ordy", 64'(out_stream_tready), 64'd1);
    send_word(32'hAAAA_0001, 1'b0);
    check("pk_half_novalid", 64'(lii_out_p0_tvalid), 64'd0);
    send_word(32'hBBBB_0002, 1'b0);
    check("pk_valid", 64'(lii_out_p0_tvalid), 64'd1);
    check("pk_data",  lii_out_p0_tdata,       64'hBBBB_0002_AAAA_0001);
    tick();
    check("pk_drained", 64'(lii_out_p0_tvalid), 64'd0);

    // tlast flush then fresh packet from lane 0
    send_word(32'hCAFE_F00D, 1'b1);
    check("tl_valid", 64'(lii_out_p0_tvalid), 64'd1);
    check("tl_data",  lii_out_p0_tdata,       64'h0000_0000_CAFE_F00D);
    tick();
    send_word(32'h0000_0011, 1'b0);
    check("tl_next_half", 64'(lii_out_p0_tvalid), 64'd0);
    send_word(32'h0000_0022, 1'b0);
    check("tl_next_data", lii_out_p0_tdata, 64'h0000_0022_0000_0011);
    tick();

    // backpressure
    lii_out_p0_tready = 1'b0;
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h0000_0002, 1'b0);
    out_stream_tvalid = 1'b1;
    out_stream_tdata  = 32'h0000_0003;
    check("bp_ce0",   64'(ce),                64'd0);
    check("bp_ordy0", 64'(out_stream_tready), 64'd0);
    check("bp_data",  lii_out_p0_tdata,       64'h0000_0002_0000_0001);
    tick();
    check("bp_hold_ce",   64'(ce),               64'd0);
    check("bp_hold_data", lii_out_p0_tdata,      64'h0000_0002_0000_0001);
    lii_out_p0_tready = 1'b1;
    #1;
    check("bp_ce1", 64'(ce), 64'd1);
    tick();
    check("bp_drained", 64'(lii_out_p0_tvalid), 64'd0);
    send_word(32'h0000_0004, 1'b0);
    check("bp_next_valid", 64'(lii_out_p0_tvalid), 64'd1);
    check("bp_next_data",  lii_out_p0_tdata,       64'h0000_0004_0000_0003);
    tick();

    // reset mid-operation
    lii_in_p0_tvalid = 1'b1;
    lii_in_p0_tdata  = 64'h0004_0003_0002_0001;
    out_stream_tvalid = 1'b1;
    out_stream_tdata  = 32'h0000_0009;
    tick();
    lii_in_p0_tvalid  = 1'b0;
    out_stream_tvalid = 1'b0;
    check("mr_w0", 64'(in_stream_tdata), 64'h0001);
    tick();
    check("mr_w1", 64'(in_stream_tdata), 64'h0002);
    tick();
    arstn = 1'b0;
    #2;
    check("mr_in_valid",  64'(in_stream_tvalid),  64'd0);
    check("mr_out_valid", 64'(lii_out_p0_tvalid), 64'd0);
    check("mr_drop",      64'(drop_count),        64'd0);
    check("mr_ce",        64'(ce),                64'd1);
    tick();
    check("mr_no_emit", 64'(lii_out_p0_tvalid), 64'd0);
    arstn = 1'b1;
    tick();
    lii_in_p0_tvalid = 1'b1;
    lii_in_p0_tdata  = 64'h000D_000C_000B_000A;
    tick();
    lii_in_p0_tvalid = 1'b0;
    check("mr_new_w0", 64'(in_stream_tdata), 64'h000A);
    tick();
    check("mr_new_w1", 64'(in_stream_tdata), 64'h000B);
    send_word(32'h0000_0005, 1'b0);
    check("mr_pk_half", 64'(lii_out_p0_tvalid), 64'd0);
    send_word(32'h0000_0006, 1'b0);
    check("mr_pk_data", lii_out_p0_tdata, 64'h0000_0006_0000_0005);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
